d_ff: RTL and testbench
=======================

D_FF -- requirements
Module: d_ff

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits (legal range 1..64).
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits), value loaded into every stage on reset.
REQ-003 Parameter DEPTH, default 1, number of cascaded register stages from D to Q (legal range 1..16).
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rstn  input  1  reset; synchronous, active-high (rstn=1 resets), sampled on rising clk edge.
REQ-006 Port: D  input  WIDTH  data captured into stage 0.
REQ-007 Port: Q  output  WIDTH  registered output, driven directly from the last stage; no combinational path from D or rstn.
REQ-008 The design shall have one clock, and its reset shall be synchronous and active-high.

Function
REQ-009 Internal state: DEPTH registers S[0..DEPTH-1], each WIDTH bits; Q = S[DEPTH-1].
REQ-010 On a rising clk edge with rstn=0: S[0] <= D; S[i] <= S[i-1] for i=1..DEPTH-1.
REQ-011 Latency: a value on D at rising edge n appears on Q after edge n+DEPTH-1 (DEPTH=1: Q follows D one edge later).
REQ-012 Throughput: one new D value accepted every cycle; no stalls, no handshake.
REQ-013 Q shall change only immediately after a rising clk edge; D or rstn changes between edges shall not affect Q.
REQ-014 Data shall pass bit-exact: no truncation, extension or inversion.
REQ-015 Reset and data capture on the same edge: reset wins; all stages load RST_VAL and D is discarded.
REQ-016 Reset asserted mid-stream: all in-flight values discarded at that edge; after deassertion the pipeline refills, and Q shows RST_VAL until the first post-reset D reaches the last stage.
REQ-017 Before the first reset edge, state is undefined; no power-on value is required.
REQ-018 Illegal parameter values (WIDTH<1, DEPTH<1) shall stop elaboration with an error.

Reset
REQ-019 Reset is synchronous only; asserting rstn without a rising clk edge shall not change Q.
REQ-020 One rising edge with rstn=1 shall set Q and all stages to RST_VAL.
REQ-021 Holding rstn=1 for multiple edges keeps all stages at RST_VAL regardless of D.
REQ-022 On the first edge with rstn=0, stage 0 captures D; no extra recovery cycle.

Verification
REQ-023 Default params; rstn=1, D=1, one edge -> Q=0; rstn=0, D=1, edge -> Q=1; D=0, edge -> Q=0.
REQ-024 Default params; 10 random D bits with rstn=0, Q sampled at each falling edge -> Q equals D applied before the preceding rising edge, every cycle.
REQ-025 Default params; rstn=1 and D=1 driven together for one edge -> Q=0 (reset priority).
REQ-026 Default params, Q=1; rstn rises and falls between two rising edges -> Q stays 1 (synchronous reset only).
REQ-027 WIDTH=8, DEPTH=3, RST_VAL=8'hA5; reset, then D=8'h01,8'h02,8'h03 on successive edges -> Q=8'hA5 after edges 1-2, then 8'h01,8'h02,8'h03 after edges 3,4,5.
REQ-028 WIDTH=8, DEPTH=3; reset asserted while 8'h11,8'h22 in flight -> Q=RST_VAL after that edge; 8'h11 and 8'h22 never appear on Q.

Source files
------------

// File: rtl/d_ff.sv
// Parameterised D flip-flop chain: DEPTH cascaded WIDTH-bit registers from D to Q.
// Synchronous active-high reset loads RST_VAL into every stage.
module d_ff #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter int                 DEPTH   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("d_ff: WIDTH must be in 1..64");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("d_ff: DEPTH must be in 1..16");
  end

  // Stage 0 sits in the low slice; the highest slice drives Q.
  logic [DEPTH-1:0][WIDTH-1:0] stage;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (rstn) stage <= RST_VAL;
      else      stage <= D;
    end
  end else begin : g_chain
    always_ff @(posedge clk) begin
      if (rstn) stage <= {DEPTH{RST_VAL}};
      else      stage <= {stage[DEPTH-2:0], D};
    end
  end

  assign Q = stage[DEPTH-1];

endmodule

// File: tb/tb_d_ff.sv
// Directed checks of d_ff: default single-bit instance and an 8-bit, 3-deep chain.
module tb_d_ff;

  logic       clk = 1'b0;
  logic       rst1 = 1'b1;
  logic       d1 = 1'b0;
  logic       q1;
  logic       rst8 = 1'b1;
  logic [7:0] d8 = 8'h00;
  logic [7:0] q8;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  d_ff u_dut1 (
    .clk  (clk),
    .rstn (rst1),
    .D    (d1),
    .Q    (q1)
  );

  d_ff #(
    .WIDTH   (8),
    .RST_VAL (8'hA5),
    .DEPTH   (3)
  ) u_dut8 (
    .clk  (clk),
    .rstn (rst8),
    .D    (d8),
    .Q    (q8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [9:0] vec;

  initial begin
    vec = 10'b1011001110;

    // Basic reset / capture on the 1-bit instance
    rst1 = 1'b1; d1 = 1'b1; step(); check("rst_q0", 64'(q1), 64'd0);
    rst1 = 1'b0; d1 = 1'b1; step(); check("cap_1", 64'(q1), 64'd1);
    d1 = 1'b0;              step(); check("cap_0", 64'(q1), 64'd0);

    // Bit stream: Q follows D one edge later
    for (int i = 0; i < 10; i++) begin
      d1 = vec[i];
      step();
      check($sformatf("stream_%0d", i), 64'(q1), 64'(vec[i]));
    end

    // Reset beats data on the same edge
    d1 = 1'b1; step(); check("pre_prio", 64'(q1), 64'd1);
    rst1 = 1'b1; d1 = 1'b1; step(); check("rst_prio", 64'(q1), 64'd0);

    // Held reset keeps the stage at RST_VAL whatever D does
    d1 = 1'b1; step(); check("rst_hold_a", 64'(q1), 64'd0);
    d1 = 1'b0; step(); check("rst_hold_b", 64'(q1), 64'd0);
    d1 = 1'b1; step(); check("rst_hold_c", 64'(q1), 64'd0);

    // First edge after release captures D, no recovery cycle
    rst1 = 1'b0; d1 = 1'b1; step(); check("no_recov", 64'(q1), 64'd1);

    // Reset pulse and D glitch between edges must not touch Q
    #1 rst1 = 1'b1;
    #1 check("async_rst", 64'(q1), 64'd1);
    rst1 = 1'b0; d1 = 1'b0;
    #1 check("async_d", 64'(q1), 64'd1);
    d1 = 1'b1;
    step(); check("after_pulse", 64'(q1), 64'd1);

    // 8-bit, 3-deep chain: fill latency
    rst8 = 1'b1; d8 = 8'hFF; step(); check("w8_rst", 64'(q8), 64'hA5);
    rst8 = 1'b0;
    d8 = 8'h01; step(); check("w8_e1", 64'(q8), 64'hA5);
    d8 = 8'h02; step(); check("w8_e2", 64'(q8), 64'hA5);
    d8 = 8'h03; step(); check("w8_e3", 64'(q8), 64'h01);
    d8 = 8'h04; step(); check("w8_e4", 64'(q8), 64'h02);
    d8 = 8'h05; step(); check("w8_e5", 64'(q8), 64'h03);

    // Mid-stream reset flushes 11/22 in flight
    d8 = 8'h11; step(); check("w8_f1", 64'(q8), 64'h04);
    d8 = 8'h22; step(); check("w8_f2", 64'(q8), 64'h05);
    rst8 = 1'b1; d8 = 8'h33; step(); check("w8_flush", 64'(q8), 64'hA5);
    rst8 = 1'b0;
    d8 = 8'h44; step(); check("w8_r1", 64'(q8), 64'hA5);
    d8 = 8'h55; step(); check("w8_r2", 64'(q8), 64'hA5);
    d8 = 8'h66; step(); check("w8_r3", 64'(q8), 64'h44);
    d8 = 8'h77; step(); check("w8_r4", 64'(q8), 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
